hls_ip_engine_adapter: RTL and testbench

- Engine-side adapter between the HWPE streamer's load/store streams and a Vivado-HLS style core with ap_ctrl_hs control and AXI-stream-like data ports.
- Per job, it accepts a beat count from the control register file, pulses the HLS start, and forwards exactly that many input beats.
- It collects the same number of output beats into a 2-entry FIFO and returns them to the streamer.
- At job end it raises a one-cycle done flag, which becomes the controller's end-of-job event.

---
 rtl/hls_ip_engine_adapter_pkg.sv | 34 +++
 rtl/hls_ip_out_fifo.sv | 60 ++++++
 rtl/hls_ip_engine_adapter.sv | 151 +++++++++++++++
 tb/tb_hls_ip_engine_adapter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_ip_engine_adapter_pkg.sv
// Shared types and defaults for the HLS engine adapter: FSM states, the job
// request and the status flags handed back to the controller.
package hls_ip_adapter_package;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                     start;
    logic [DEF_CNT_WIDTH-1:0] len;
  } ctrl_t;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [DEF_CNT_WIDTH-1:0] in_cnt;
    logic [DEF_CNT_WIDTH-1:0] out_cnt;
  } flags_t;

  // States in which a job owns the core and the output path is open.
  function automatic logic is_active(input state_e s);
    return (s == ST_START) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/hls_ip_out_fifo.sv
// Two-entry valid/ready FIFO with registered output and synchronous flush;
// no bypass, so data spends at least one cycle inside.
module hls_ip_out_fifo
  import hls_ip_adapter_package::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_ready
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count_q == 2'd2);
  assign pop_valid = (count_q != 2'd0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign do_pop    = pop_valid && pop_ready;
  assign do_push   = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through pop_valid, which is driven by the reset count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hls_ip_engine_adapter.sv
// Adapter between HWPE streamer load/store streams and an ap_ctrl_hs HLS core:
// starts the core, forwards len input beats and collects len output beats.
module hls_ip_engine_adapter
  import hls_ip_adapter_package::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_strb_i,
  output logic                    hls_start_o,
  input  logic                    hls_idle_i,
  input  logic                    hls_done_i,
  output logic                    hls_in_valid_o,
  input  logic                    hls_in_ready_i,
  output logic [DATA_WIDTH-1:0]   hls_in_data_o,
  input  logic                    hls_out_valid_i,
  output logic                    hls_out_ready_o,
  input  logic [DATA_WIDTH-1:0]   hls_out_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [DATA_WIDTH/8-1:0] out_strb_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    in_cnt_o,
  output logic [CNT_WIDTH-1:0]    out_cnt_o
);

  state_e               state_q, state_d;
  ctrl_t                req;
  flags_t               flags;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] in_cnt_q;
  logic [CNT_WIDTH-1:0] out_cnt_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;
  logic                 err_q;
  logic                 done_seen_q;

  logic active, start_accept, in_open, in_fire, out_fire;
  logic core_fire, core_extra, fifo_full, fifo_valid;

  assign req          = '{start: start_i, len: len_i};
  assign active       = is_active(state_q);
  assign start_accept = (state_q == ST_IDLE) && req.start;

  // Input path is a pure pass-through, gated once the job length is reached.
  assign in_open        = (state_q == ST_RUN) && (in_cnt_q < len_q);
  assign hls_in_valid_o = in_valid_i && in_open;
  assign in_ready_o     = hls_in_ready_i && in_open;
  assign hls_in_data_o  = in_data_i;
  assign in_fire        = in_valid_i && in_ready_o;

  // Core beats beyond len are still accepted so the core never deadlocks.
  assign hls_out_ready_o = active && !fifo_full;
  assign core_fire       = hls_out_valid_i && hls_out_ready_o;
  assign core_extra      = (wr_cnt_q == len_q);

  assign out_valid_o = fifo_valid;
  assign out_strb_o  = '1;
  assign out_fire    = out_valid_o && out_ready_i;
  assign hls_start_o = (state_q == ST_START);

  hls_ip_out_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (clear_i),
    .push      (core_fire && !core_extra),
    .push_data (hls_out_data_i),
    .full      (fifo_full),
    .pop_valid (fifo_valid),
    .pop_data  (out_data_o),
    .pop_ready (out_ready_i)
  );

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req.start) state_d = (req.len == '0) ? ST_DONE : ST_START;
      ST_START: if (!hls_idle_i || hls_done_i) state_d = ST_RUN;
      ST_RUN:   if (in_cnt_q == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((out_cnt_q == len_q) && !fifo_valid && done_seen_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      err_q       <= 1'b0;
      done_seen_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      err_q       <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_accept) begin
        len_q       <= req.len;
        in_cnt_q    <= '0;
        out_cnt_q   <= '0;
        wr_cnt_q    <= '0;
        err_q       <= 1'b0;
        done_seen_q <= 1'b0;
      end else begin
        if (in_fire) in_cnt_q <= in_cnt_q + CNT_WIDTH'(1);
        if (out_fire && (out_cnt_q < len_q)) out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
        if (core_fire && !core_extra) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
        if ((in_fire && !(&in_strb_i)) || (core_fire && core_extra)) err_q <= 1'b1;
        // ap_done may arrive before the last output beat is drained.
        if (active && hls_done_i) done_seen_q <= 1'b1;
      end
    end
  end

  assign flags = '{
    busy:    active,
    done:    (state_q == ST_DONE),
    err:     err_q,
    in_cnt:  in_cnt_q,
    out_cnt: out_cnt_q
  };

  assign busy_o    = flags.busy;
  assign done_o    = flags.done;
  assign err_o     = flags.err;
  assign in_cnt_o  = flags.in_cnt;
  assign out_cnt_o = flags.out_cnt;

endmodule

// File: tb/tb_hls_ip_engine_adapter.sv
// Bench for hls_ip_engine_adapter: an echo-plus-one HLS core model, a directed
// streamer driver and a scoreboard monitor on the store stream.
module tb_hls_ip_engine_adapter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i, start_i;
  logic [15:0] len_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_data_i;
  logic [3:0]  in_strb_i;
  logic        hls_start_o, hls_idle_i, hls_done_i;
  logic        hls_in_valid_o, hls_in_ready_i;
  logic [31:0] hls_in_data_o;
  logic        hls_out_valid_i, hls_out_ready_o;
  logic [31:0] hls_out_data_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_data_o;
  logic [3:0]  out_strb_o;
  logic        busy_o, done_o, err_o;
  logic [15:0] in_cnt_o, out_cnt_o;

  always #5 clk_i = ~clk_i;

  hls_ip_engine_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_strb_i(in_strb_i),
    .hls_start_o(hls_start_o), .hls_idle_i(hls_idle_i), .hls_done_i(hls_done_i),
    .hls_in_valid_o(hls_in_valid_o), .hls_in_ready_i(hls_in_ready_i), .hls_in_data_o(hls_in_data_o),
    .hls_out_valid_i(hls_out_valid_i), .hls_out_ready_o(hls_out_ready_o), .hls_out_data_i(hls_out_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_strb_o(out_strb_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] core_q[$];
  int core_len = 0, core_extra = 0;
  bit slow = 0;
  int rcyc = 0;

  int neg_cnt = 0, start_at = 0;
  int done_pulses = 0, done_at = 0, done_width = 0;
  int done_in = 0, done_out = 0, done_store = 0;
  logic done_err = 1'b0;
  bit busy_seen = 0, start_prev = 0, done_prev = 0;
  int start_rises = 0, full_seen = 0, ready_bad = 0, store_cnt = 0;
  int occ = 0, wr_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: store-stream transfers are compared against the queue.
  always @(negedge clk_i) begin
    neg_cnt++;
    if (rst_ni && clear_i) begin
      sb_q.delete();
      occ = 0;
    end else if (rst_ni) begin
      if (busy_o) busy_seen = 1;
      if (hls_start_o && !start_prev) start_rises++;
      if (busy_o && !hls_out_ready_o) full_seen++;
      if (busy_o && (hls_out_ready_o != (occ < 2))) ready_bad++;
      if (hls_out_valid_i && hls_out_ready_o && (wr_model < core_len)) begin
        occ++;
        wr_model++;
      end
      if (out_valid_o && out_ready_i) begin
        occ--;
        store_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL store_unexpected: got 0x%0h with no beat expected", out_data_o);
        end else begin
          check("store_data", out_data_o, sb_q.pop_front());
        end
      end
      if (done_o) begin
        if (!done_prev) begin
          done_pulses++;
          done_at    = neg_cnt;
          done_width = 0;
          done_in    = int'(in_cnt_o);
          done_out   = int'(out_cnt_o);
          done_err   = err_o;
          done_store = store_cnt;
        end
        done_width++;
      end
    end
    start_prev = hls_start_o;
    done_prev  = done_o;
  end

  // HLS core model: ap_ctrl_hs handshake, echoes each input + 1 one cycle later.
  initial begin
    logic        in_x, out_x, st, clr;
    logic [31:0] in_d;
    int          c_in, c_out;
    bit          running;
    hls_idle_i = 1'b1; hls_done_i = 1'b0; hls_out_valid_i = 1'b0; hls_out_data_i = '0;
    c_in = 0; c_out = 0; running = 0;
    forever begin
      @(negedge clk_i);
      in_x  = hls_in_valid_o && hls_in_ready_i;
      in_d  = hls_in_data_o;
      out_x = hls_out_valid_i && hls_out_ready_o;
      st    = hls_start_o && hls_idle_i;
      clr   = clear_i;
      @(posedge clk_i); #1;
      hls_done_i = 1'b0;
      if (clr) begin
        core_q.delete(); c_in = 0; c_out = 0; running = 0; hls_idle_i = 1'b1;
      end else begin
        if (st) begin
          hls_idle_i = 1'b0; running = 1; c_in = 0; c_out = 0;
        end
        if (out_x) begin
          void'(core_q.pop_front());
          c_out++;
        end
        if (in_x) begin
          core_q.push_back(in_d + 32'd1);
          c_in++;
          if (c_in == core_len)
            for (int k = 0; k < core_extra; k++) core_q.push_back(32'hDEAD_0000 + k);
        end
        if (running && (c_in == core_len) && (c_out == core_len + core_extra) && (core_q.size() == 0)) begin
          hls_done_i = 1'b1; hls_idle_i = 1'b1; running = 0;
        end
      end
      hls_out_valid_i = (core_q.size() != 0);
      hls_out_data_i  = (core_q.size() != 0) ? core_q[0] : '0;
    end
  end

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      rcyc++;
      out_ready_i = slow ? ((rcyc % 3) == 0) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input int budget, output bit ok);
    in_valid_i = 1'b1; in_data_i = d; in_strb_i = s; ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk_i);
      if (in_ready_o) ok = 1;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    if (ok) sb_q.push_back(d + 32'd1);
  endtask

  task automatic start_job(input string name, input int len);
    occ = 0; wr_model = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; len_i = 16'(len); start_at = neg_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check({name, "_err_clr_on_start"}, err_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic run_job(input string name, input int len, input int n_offer, input int step,
                         input int extra, input int bad_idx, input bit exp_err);
    int  accepted, exp_acc, d0;
    bit  ok;
    core_len = len; core_extra = extra;
    busy_seen = 0; start_rises = 0; full_seen = 0; ready_bad = 0; store_cnt = 0;
    d0 = done_pulses; accepted = 0;
    exp_acc = (n_offer < len) ? n_offer : len;
    start_job(name, len);
    for (int i = 0; i < n_offer; i++) begin
      send_beat(32'(step * (i + 1)), (i == bad_idx) ? 4'h7 : 4'hF, (i < len) ? 200 : 20, ok);
      if (ok) accepted++;
    end
    check({name, "_accepted"}, accepted, exp_acc);
    if (n_offer > len) begin
      @(negedge clk_i);
      check({name, "_in_ready_low"}, in_ready_o, 0);
    end
    for (int c = 0; c < 1000 && done_pulses == d0; c++) @(negedge clk_i);
    check({name, "_done_seen"}, done_pulses - d0, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    check({name, "_done_width"}, done_width, 1);
    check({name, "_in_cnt"}, done_in, len);
    check({name, "_out_cnt"}, done_out, len);
    check({name, "_store_at_done"}, done_store, len);
    check({name, "_done_err"}, done_err, exp_err);
    check({name, "_err_sticky"}, err_o, exp_err);
    check({name, "_sb_empty"}, sb_q.size(), 0);
    check({name, "_start_pulses"}, start_rises, (len != 0) ? 1 : 0);
    check({name, "_busy_seen"}, busy_seen, (len != 0) ? 1 : 0);
    check({name, "_out_ready_vs_fill"}, ready_bad, 0);
    if (len == 0) check({name, "_done_latency"}, done_at - start_at, 2);
    if (slow) check({name, "_fifo_full_seen"}, full_seen > 0, 1);
  endtask

  initial begin
    bit ok;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; in_strb_i = 4'hF; hls_in_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_hls_start", hls_start_o, 0);
    check("rst_in_cnt", in_cnt_o, 0);
    check("rst_out_cnt", out_cnt_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_strb", out_strb_o, 4'hF);

    run_job("basic", 4, 4, 10, 0, -1, 1'b0);
    run_job("zero", 0, 0, 1, 0, -1, 1'b0);
    run_job("over", 3, 5, 5, 0, -1, 1'b0);
    slow = 1;
    run_job("slow", 8, 8, 3, 0, -1, 1'b0);
    slow = 0;
    run_job("extra", 4, 4, 7, 1, -1, 1'b1);
    run_job("strb", 2, 2, 9, 0, 1, 1'b1);

    // Soft clear in the middle of a job, with a coincident start request.
    core_len = 6; core_extra = 0;
    start_job("clr", 6);
    send_beat(32'd1, 4'hF, 200, ok);
    send_beat(32'd2, 4'hF, 200, ok);
    @(negedge clk_i);
    check("clr_pre_in_cnt", in_cnt_o, 2);
    @(posedge clk_i); #1;
    clear_i = 1'b1; start_i = 1'b1; len_i = 16'd5;
    @(posedge clk_i); #1;
    clear_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    check("clr_busy", busy_o, 0);
    check("clr_hls_start", hls_start_o, 0);
    check("clr_in_cnt", in_cnt_o, 0);
    check("clr_out_cnt", out_cnt_o, 0);
    check("clr_out_valid", out_valid_o, 0);
    check("clr_in_ready", in_ready_o, 0);
    repeat (3) @(negedge clk_i);
    check("clr_start_ignored", busy_o, 0);
    check("clr_hls_start_later", hls_start_o, 0);

    run_job("post_clr", 2, 2, 100, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
